vault_code_checker: RTL and testbench
=====================================

Name: vault_code_checker

Overview:
- Companion to the vault lock FSM: produces the MATCH input that the FSM consumes, and consumes the FSM's 2-bit state output.
- Stores the password keyed in while the vault is open, and compares each code entered while locked.
- Counts consecutive wrong entries; after MAX_FAILS it enters a timed lockout in which no entry can match.

Parameters:
- CODE_W, 4, width of the switch code and stored password.
- MAX_FAILS, 3, consecutive wrong entries that trigger lockout (>=1).
- LOCKOUT_CYCLES, 1000, clock cycles LOCKOUT stays high (>=1).
- MASTER_CODE, 0, override code; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- RESETN  input  1  asynchronous active-low reset.
- ENTER  input  1  entry button, already synchronous to clk, active-high.
- SWITCHES  input  CODE_W  code being keyed in.
- LOCK_STATE  input  2  FSM state: 00 OPEN_FROZEN, 01 OPEN_FREE, 10 LOCKED_FROZEN, 11 LOCKED_FREE.
- MATCH  output  1  registered; 1 = last evaluated entry was correct.
- CODE_SET  output  1  a password has been stored since reset.
- FAIL_COUNT  output  $clog2(MAX_FAILS+1)  consecutive wrong entries.
- LOCKOUT  output  1  lockout in progress.

Behaviour:
- Reset (asynchronous, RESETN low):
  - MATCH=0, CODE_SET=0, FAIL_COUNT=0, LOCKOUT=0.
  - Password register=0, lockout timer=0, ENTER history flop=0.
- Edge detect: rise = ENTER & ~enter_q. enter_q is registered every cycle.
- Internal states: NO_CODE, ARMED, LOCKED_OUT. Reset state is NO_CODE.
- Store (rise while LOCK_STATE=00, any internal state except LOCKED_OUT):
  - At that edge: password<=SWITCHES, CODE_SET<=1, MATCH<=0, FAIL_COUNT<=0, state->ARMED.
  - A later store overwrites the password.
- Evaluate (rise while LOCK_STATE=10, state ARMED):
  - At that edge: MATCH<=(SWITCHES==password). Latency is 1 cycle, so MATCH is valid at the edge where the FSM samples ENTER low.
  - Correct entry: FAIL_COUNT<=0.
  - Wrong entry: FAIL_COUNT<=FAIL_COUNT+1.
  - If the increment reaches MAX_FAILS: LOCKOUT<=1 at the same edge, timer<=LOCKOUT_CYCLES-1, state->LOCKED_OUT.
- Rise while LOCK_STATE=10 and state NO_CODE: MATCH<=0, FAIL_COUNT unchanged.
- Rise while LOCK_STATE=01 or 11: ignored.
- MATCH holds its value until the next evaluate or store, or until LOCK_STATE=00, which clears it the next cycle.
- LOCKED_OUT:
  - Every rise is ignored: MATCH stays 0, FAIL_COUNT stays at MAX_FAILS, and the password is not overwritten.
  - The timer decrements each cycle.
  - On the cycle the timer is 0: LOCKOUT<=0, FAIL_COUNT<=0, state->ARMED.
  - Net effect: LOCKOUT is high for exactly LOCKOUT_CYCLES cycles.
- Simultaneous events:
  - The lockout-expiry cycle coinciding with a rise: the rise is ignored.
  - LOCK_STATE changes in the same cycle as a rise: the registered LOCK_STATE value sampled at that edge decides the action.
- Reset mid-lockout or mid-entry: all state clears immediately, and the password is lost (CODE_SET=0).

Optional Feature:
- Macro VAULT_MASTER_CODE_EN.
- Defined: an evaluate with SWITCHES==MASTER_CODE gives MATCH<=1, FAIL_COUNT<=0. This also applies in LOCKED_OUT and NO_CODE: it ends any lockout (LOCKOUT<=0, state->ARMED if CODE_SET, else NO_CODE).
- Undefined: MASTER_CODE is unused and no master-code comparison logic is synthesized.

Test Plan:
- Reset, LOCK_STATE=00, SWITCHES=4'hA, pulse ENTER for 1 cycle -> next cycle CODE_SET=1, MATCH=0, FAIL_COUNT=0.
- After the store, LOCK_STATE=10, SWITCHES=4'hA, 1-cycle ENTER -> MATCH=1 exactly 1 cycle after the rising edge; then LOCK_STATE=00 -> MATCH=0 the next cycle.
- Stored 4'hA, three evaluates with 4'h3 -> FAIL_COUNT 1,2,3; LOCKOUT=1 after the 3rd rise, high for 1000 cycles, then LOCKOUT=0, FAIL_COUNT=0.
- During lockout, evaluate with 4'hA -> MATCH stays 0, LOCKOUT is unaffected; without the macro, MASTER_CODE=0 with SWITCHES=0 also gives no match.
- Two wrong entries then a correct one -> FAIL_COUNT 1,2,0, MATCH=1, LOCKOUT never asserted.
- RESETN low mid-lockout (cycle 500) -> all outputs 0 immediately, without waiting for clk; a following evaluate with 4'hA -> MATCH=0 (NO_CODE).

Source files
------------

// File: rtl/vault_code_checker_if.sv
// rtl/vault_code_checker_if.sv - entry/result bundle between the vault lock FSM side and the code checker
interface vault_code_checker_if #(
    parameter int CODE_W    = 4,
    parameter int MAX_FAILS = 3
);
    localparam int FW = $clog2(MAX_FAILS + 1);

    logic              ENTER;
    logic [CODE_W-1:0] SWITCHES;
    logic [1:0]        LOCK_STATE;
    logic              MATCH;
    logic              CODE_SET;
    logic [FW-1:0]     FAIL_COUNT;
    logic              LOCKOUT;

    modport master (
        output ENTER, SWITCHES, LOCK_STATE,
        input  MATCH, CODE_SET, FAIL_COUNT, LOCKOUT
    );

    modport slave (
        input  ENTER, SWITCHES, LOCK_STATE,
        output MATCH, CODE_SET, FAIL_COUNT, LOCKOUT
    );
endinterface

// File: rtl/vault_code_checker.sv
// rtl/vault_code_checker.sv - password store/compare with fail counting and timed lockout
// Optional master override code enabled by defining VAULT_MASTER_CODE_EN.
module vault_code_checker #(
    parameter int CODE_W         = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int MASTER_CODE    = 0
) (
    input  logic                 clk,
    input  logic                 RESETN,
    vault_code_checker_if.slave  bus
);
    localparam int              FW         = $clog2(MAX_FAILS + 1);
    localparam int              TW         = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [FW-1:0]   FAIL_MAX   = FW'(MAX_FAILS);
    localparam logic [TW-1:0]   TIMER_INIT = TW'(LOCKOUT_CYCLES - 1);

    if (MAX_FAILS < 1 || LOCKOUT_CYCLES < 1 || MASTER_CODE < 0 ||
        longint'(MASTER_CODE) >= (longint'(1) << CODE_W)) begin : g_bad_params
        $error("vault_code_checker: parameter out of range");
    end

    typedef enum logic [1:0] {NO_CODE, ARMED, LOCKED_OUT} state_t;

    state_t            state_q;
    logic [CODE_W-1:0] password_q;
    logic [TW-1:0]     timer_q;
    logic [FW-1:0]     fail_q;
    logic              enter_q;
    logic              match_q;
    logic              code_set_q;
    logic              lockout_q;

    logic              rise;
    logic              store;
    logic              evaluate;
    logic              correct;
    logic              master_hit;
    logic [FW-1:0]     fail_d;

    assign rise     = bus.ENTER & ~enter_q;
    assign store    = rise && (bus.LOCK_STATE == 2'b00) && (state_q != LOCKED_OUT);
    assign evaluate = rise && (bus.LOCK_STATE == 2'b10);
    assign correct  = (bus.SWITCHES == password_q);
    assign fail_d   = fail_q + 1'b1;

`ifdef VAULT_MASTER_CODE_EN
    assign master_hit = evaluate && (bus.SWITCHES == CODE_W'(MASTER_CODE));
`else
    assign master_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= NO_CODE;
            password_q <= '0;
            timer_q    <= '0;
            fail_q     <= '0;
            enter_q    <= 1'b0;
            match_q    <= 1'b0;
            code_set_q <= 1'b0;
            lockout_q  <= 1'b0;
        end else begin
            enter_q <= bus.ENTER;
            if (master_hit) begin
                // Override wins over everything, including a pending lockout expiry.
                match_q   <= 1'b1;
                fail_q    <= '0;
                lockout_q <= 1'b0;
                timer_q   <= '0;
                state_q   <= code_set_q ? ARMED : NO_CODE;
            end else begin
                case (state_q)
                    LOCKED_OUT: begin
                        match_q <= 1'b0;
                        if (timer_q == '0) begin
                            lockout_q <= 1'b0;
                            fail_q    <= '0;
                            state_q   <= ARMED;
                        end else begin
                            timer_q <= timer_q - 1'b1;
                        end
                    end
                    default: begin
                        if (store) begin
                            password_q <= bus.SWITCHES;
                            code_set_q <= 1'b1;
                            match_q    <= 1'b0;
                            fail_q     <= '0;
                            state_q    <= ARMED;
                        end else if (evaluate && state_q == ARMED) begin
                            match_q <= correct;
                            if (correct) begin
                                fail_q <= '0;
                            end else begin
                                fail_q <= fail_d;
                                if (fail_d == FAIL_MAX) begin
                                    lockout_q <= 1'b1;
                                    timer_q   <= TIMER_INIT;
                                    state_q   <= LOCKED_OUT;
                                end
                            end
                        end else if (evaluate || bus.LOCK_STATE == 2'b00) begin
                            match_q <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.MATCH      = match_q;
    assign bus.CODE_SET   = code_set_q;
    assign bus.FAIL_COUNT = fail_q;
    assign bus.LOCKOUT    = lockout_q;
endmodule

// File: tb/tb_vault_code_checker.sv
// tb/tb_vault_code_checker.sv - self-checking bench for vault_code_checker (default build)
module tb_vault_code_checker;
    logic clk = 1'b0;
    logic RESETN = 1'b0;

    vault_code_checker_if #(.CODE_W(4), .MAX_FAILS(3)) bus ();

    vault_code_checker #(
        .CODE_W(4), .MAX_FAILS(3), .LOCKOUT_CYCLES(1000), .MASTER_CODE(0)
    ) dut (
        .clk    (clk),
        .RESETN (RESETN),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ls;
        logic [3:0] sw;
        logic       m;
        logic [1:0] fc;
        logic       lo;
        logic       cs;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   lo_cnt = 0;
    vec_t exp_q[$];
    vec_t vecs[10];

    always @(negedge clk) if (bus.LOCKOUT === 1'b1) lo_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t e);
        chk({tag, ".MATCH"},      32'(bus.MATCH),      32'(e.m));
        chk({tag, ".FAIL_COUNT"}, 32'(bus.FAIL_COUNT), 32'(e.fc));
        chk({tag, ".LOCKOUT"},    32'(bus.LOCKOUT),    32'(e.lo));
        chk({tag, ".CODE_SET"},   32'(bus.CODE_SET),   32'(e.cs));
    endtask

    task automatic press(input string tag, input logic [1:0] ls, input logic [3:0] sw,
                         input logic m, input logic [1:0] fc, input logic lo, input logic cs);
        vec_t e;
        e = '{ls: ls, sw: sw, m: m, fc: fc, lo: lo, cs: cs};
        @(negedge clk);
        bus.LOCK_STATE = ls;
        bus.SWITCHES   = sw;
        bus.ENTER      = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        bus.ENTER = 1'b0;
        if (exp_q.size() == 0) begin
            chk({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk_all(tag, e);
        end
    endtask

    task automatic wait_lockout_end(input string tag);
        bit done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (bus.LOCKOUT === 1'b0) done = 1;
        end
        if (!done) chk({tag, ".timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ENTER      = 1'b0;
        bus.SWITCHES   = '0;
        bus.LOCK_STATE = 2'b00;

        vecs[0] = '{ls: 2'b00, sw: 4'hA, m: 1'b0, fc: 2'd0, lo: 1'b0, cs: 1'b1};
        vecs[1] = '{ls: 2'b10, sw: 4'hA, m: 1'b1, fc: 2'd0, lo: 1'b0, cs: 1'b1};
        vecs[2] = '{ls: 2'b10, sw: 4'h3, m: 1'b0, fc: 2'd1, lo: 1'b0, cs: 1'b1};
        vecs[3] = '{ls: 2'b10, sw: 4'h3, m: 1'b0, fc: 2'd2, lo: 1'b0, cs: 1'b1};
        vecs[4] = '{ls: 2'b10, sw: 4'hA, m: 1'b1, fc: 2'd0, lo: 1'b0, cs: 1'b1};
        vecs[5] = '{ls: 2'b00, sw: 4'h5, m: 1'b0, fc: 2'd0, lo: 1'b0, cs: 1'b1};
        vecs[6] = '{ls: 2'b10, sw: 4'hA, m: 1'b0, fc: 2'd1, lo: 1'b0, cs: 1'b1};
        vecs[7] = '{ls: 2'b10, sw: 4'h5, m: 1'b1, fc: 2'd0, lo: 1'b0, cs: 1'b1};
        vecs[8] = '{ls: 2'b01, sw: 4'h3, m: 1'b1, fc: 2'd0, lo: 1'b0, cs: 1'b1};
        vecs[9] = '{ls: 2'b11, sw: 4'h3, m: 1'b1, fc: 2'd0, lo: 1'b0, cs: 1'b1};

        repeat (3) @(negedge clk);
        chk_all("reset", '{ls: 2'b00, sw: 4'h0, m: 1'b0, fc: 2'd0, lo: 1'b0, cs: 1'b0});
        RESETN = 1'b1;

        for (int i = 0; i < 10; i++) begin
            press($sformatf("vec%0d", i), vecs[i].ls, vecs[i].sw,
                  vecs[i].m, vecs[i].fc, vecs[i].lo, vecs[i].cs);
        end

        // MATCH clears the cycle after LOCK_STATE returns to open-frozen
        @(negedge clk);
        bus.LOCK_STATE = 2'b00;
        @(negedge clk);
        chk("open_clears_match", 32'(bus.MATCH), 32'd0);

        press("restore", 2'b00, 4'hA, 1'b0, 2'd0, 1'b0, 1'b1);
        lo_cnt = 0;
        press("lock_w1", 2'b10, 4'h3, 1'b0, 2'd1, 1'b0, 1'b1);
        press("lock_w2", 2'b10, 4'h3, 1'b0, 2'd2, 1'b0, 1'b1);
        press("lock_w3", 2'b10, 4'h3, 1'b0, 2'd3, 1'b1, 1'b1);
        press("lo_good", 2'b10, 4'hA, 1'b0, 2'd3, 1'b1, 1'b1);
        press("lo_store", 2'b00, 4'h7, 1'b0, 2'd3, 1'b1, 1'b1);
        press("lo_master", 2'b10, 4'h0, 1'b0, 2'd3, 1'b1, 1'b1);
        wait_lockout_end("lockout");
        chk("lockout_len", 32'(lo_cnt), 32'd1000);
        chk("post_lo.FAIL_COUNT", 32'(bus.FAIL_COUNT), 32'd0);
        chk("post_lo.LOCKOUT", 32'(bus.LOCKOUT), 32'd0);
        press("post_lo_pw", 2'b10, 4'hA, 1'b1, 2'd0, 1'b0, 1'b1);
        press("master_off", 2'b10, 4'h0, 1'b0, 2'd1, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a lockout
        press("rst_w1", 2'b10, 4'h3, 1'b0, 2'd2, 1'b0, 1'b1);
        press("rst_w2", 2'b10, 4'h3, 1'b0, 2'd3, 1'b1, 1'b1);
        repeat (497) @(negedge clk);
        #2 RESETN = 1'b0;
        #1;
        chk_all("async_rst", '{ls: 2'b10, sw: 4'h3, m: 1'b0, fc: 2'd0, lo: 1'b0, cs: 1'b0});
        @(negedge clk);
        RESETN = 1'b1;
        press("no_code_eval", 2'b10, 4'hA, 1'b0, 2'd0, 1'b0, 1'b0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
